// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, (conditional) jump, call/return through a
// small LIFO stack, and halt. Addr is fully registered.
module pc_sequencer #(
    parameter int unsigned          ADDR_W     = 5,
    parameter int unsigned          STACK_D    = 4,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              En,
    input  logic              Jmp,
    input  logic [1:0]        JmpCond,
    input  logic [ADDR_W-1:0] Target,
    input  logic              Call,
    input  logic              Ret,
    input  logic              Halt,
    input  logic              CY,
    input  logic              AZero,
    output logic [ADDR_W-1:0] Addr,
    output logic              Halted,
    output logic              StackErr
);

    localparam int unsigned SP_W  = $clog2(STACK_D + 1);
    localparam int unsigned IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_dec;
    logic [ADDR_W-1:0] stack_mem [STACK_D];
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] stack_top;
    logic              full;
    logic              empty;
    logic              jmp_taken;
    logic              step;
    logic              push;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        addr_inc  = Addr + ADDR_W'(1);
        sp_dec    = sp - SP_W'(1);
        full      = (sp == SP_W'(STACK_D));
        empty     = (sp == '0);
        stack_top = stack_mem[sp_dec[IDX_W-1:0]];
        jmp_taken = 1'b1;
        unique case (JmpCond)
            2'b00:   jmp_taken = 1'b1;
            2'b01:   jmp_taken = CY;
            2'b10:   jmp_taken = !CY;
            default: jmp_taken = AZero;
        endcase
        step = !Reset && (state == RUN) && En;
        push = step && !Halt && !Ret && Call && !full;
    end

    // NOTE: the stack storage is deliberately not reset; sp==0 already marks it
    // empty, so clearing the entries would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp[IDX_W-1:0]] <= addr_inc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= RUN;
            Addr     <= RESET_ADDR;
            sp       <= '0;
            Halted   <= 1'b0;
            StackErr <= 1'b0;
        end else if (step) begin
            if (Halt) begin
                state  <= HALT;
                Halted <= 1'b1;
            end else if (Ret) begin
                if (!empty) begin
                    Addr <= stack_top;
                    sp   <= sp_dec;
                end else begin
                    StackErr <= 1'b1;
                    Addr     <= addr_inc;
                end
            end else if (Call) begin
                // A call into a full stack is dropped and behaves as a plain step.
                if (!full) begin
                    Addr <= Target;
                    sp   <= sp + SP_W'(1);
                end else begin
                    StackErr <= 1'b1;
                    Addr     <= addr_inc;
                end
            end else if (Jmp && jmp_taken) begin
                Addr <= Target;
            end else begin
                Addr <= addr_inc;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       Reset, En, Jmp, Call, Ret, Halt, CY, AZero;
    logic [1:0] JmpCond;
    logic [4:0] Target;
    logic [4:0] Addr;
    logic       Halted, StackErr;

    int tests = 0;
    int fails = 0;

    pc_sequencer #(.ADDR_W(5), .STACK_D(4), .RESET_ADDR(5'd0)) dut (
        .clk(clk), .Reset(Reset), .En(En), .Jmp(Jmp), .JmpCond(JmpCond),
        .Target(Target), .Call(Call), .Ret(Ret), .Halt(Halt), .CY(CY),
        .AZero(AZero), .Addr(Addr), .Halted(Halted), .StackErr(StackErr)
    );

    always #5 clk = !clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: addresses as plain integers mod 32, stack as a queue.
    int m_addr = 0;
    int m_stack[$];
    bit m_halted = 0;
    bit m_err = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        bit cond;
        case (JmpCond)
            2'd0:    cond = 1;
            2'd1:    cond = (CY == 1'b1);
            2'd2:    cond = (CY == 1'b0);
            default: cond = (AZero == 1'b1);
        endcase
        if (Reset) begin
            m_addr = 0;
            m_stack.delete();
            m_halted = 0;
            m_err = 0;
            m_valid = 1;
        end else if (m_valid && !m_halted && En) begin
            if (Halt) begin
                m_halted = 1;
            end else if (Ret) begin
                if (m_stack.size() > 0) begin
                    m_addr = m_stack.pop_back();
                end else begin
                    m_err = 1;
                    m_addr = (m_addr + 1) % 32;
                end
            end else if (Call) begin
                if (m_stack.size() < 4) begin
                    m_stack.push_back((m_addr + 1) % 32);
                    m_addr = int'(Target);
                end else begin
                    m_err = 1;
                    m_addr = (m_addr + 1) % 32;
                end
            end else if (Jmp && cond) begin
                m_addr = int'(Target);
            end else begin
                m_addr = (m_addr + 1) % 32;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_addr", 32'(Addr), 32'(m_addr));
            check("model_halted", 32'(Halted), 32'(m_halted));
            check("model_stackerr", 32'(StackErr), 32'(m_err));
        end
    end

    task automatic cyc(input bit rst, input bit en, input bit jmp, input logic [1:0] cond,
                       input int tgt, input bit call, input bit ret, input bit halt,
                       input bit cy, input bit az);
        Reset   = rst;
        En      = en;
        Jmp     = jmp;
        JmpCond = cond;
        Target  = 5'(tgt);
        Call    = call;
        Ret     = ret;
        Halt    = halt;
        CY      = cy;
        AZero   = az;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input int tgt);
        cyc(0, 1, 1, 2'd0, tgt, 0, 0, 0, 0, 0);
    endtask

    task automatic call_to(input int tgt);
        cyc(0, 1, 0, 2'd0, tgt, 1, 0, 0, 0, 0);
    endtask

    task automatic ret_op();
        cyc(0, 1, 0, 2'd0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        // Reset held two cycles.
        cyc(1, 1, 1, 2'd0, 17, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 2'd0, 17, 1, 0, 0, 0, 0);
        check("reset_addr", 32'(Addr), 0);
        check("reset_halted", 32'(Halted), 0);
        check("reset_err", 32'(StackErr), 0);

        // Free run with wrap 31 -> 0.
        for (int i = 0; i < 34; i++) begin
            step();
            check("incr_addr", 32'(Addr), 32'((i + 1) % 32));
        end
        step();
        check("at_3", 32'(Addr), 3);

        // Conditional jump on carry.
        cyc(0, 1, 1, 2'd1, 20, 0, 0, 0, 0, 0);
        check("jc_not_taken", 32'(Addr), 4);
        cyc(0, 1, 1, 2'd1, 20, 0, 0, 0, 1, 0);
        check("jc_taken", 32'(Addr), 20);
        cyc(0, 1, 1, 2'd2, 2, 0, 0, 0, 1, 0);
        check("jnc_not_taken", 32'(Addr), 21);
        cyc(0, 1, 1, 2'd3, 7, 0, 0, 0, 0, 1);
        check("jz_taken", 32'(Addr), 7);

        // Call / return.
        jump(5);
        call_to(12);
        check("call_addr", 32'(Addr), 12);
        ret_op();
        check("ret_addr", 32'(Addr), 6);
        check("ret_err", 32'(StackErr), 0);

        // Overflow then underflow.
        call_to(10);
        call_to(20);
        call_to(30);
        call_to(31);
        check("nest4_addr", 32'(Addr), 31);
        call_to(1);
        check("overflow_addr", 32'(Addr), 0);
        check("overflow_err", 32'(StackErr), 1);
        ret_op();
        check("ret1", 32'(Addr), 31);
        ret_op();
        check("ret2", 32'(Addr), 21);
        ret_op();
        check("ret3", 32'(Addr), 11);
        ret_op();
        check("ret4", 32'(Addr), 7);
        ret_op();
        check("underflow_addr", 32'(Addr), 8);
        check("underflow_err", 32'(StackErr), 1);

        // Halt wins over a same-cycle jump, then ignores everything.
        jump(9);
        cyc(0, 1, 1, 2'd0, 25, 0, 0, 1, 0, 0);
        check("halt_addr", 32'(Addr), 9);
        check("halt_flag", 32'(Halted), 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, 2'd0, 14, i[0], i[1], 0, 1, 1);
            check("halted_hold", 32'(Addr), 9);
        end
        cyc(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        check("halt_reset_addr", 32'(Addr), 0);
        check("halt_reset_flag", 32'(Halted), 0);
        check("halt_reset_err", 32'(StackErr), 0);

        // Return address pushed from 31 wraps to 0.
        jump(31);
        call_to(4);
        ret_op();
        check("wrap_return", 32'(Addr), 0);

        // Stall ignores a jump; reset during stall still applies.
        jump(13);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 2'd0, 22, 0, 0, 0, 0, 0);
            check("stall_hold", 32'(Addr), 13);
        end
        cyc(1, 0, 1, 2'd0, 22, 0, 0, 0, 0, 0);
        check("stall_reset", 32'(Addr), 0);

        // Randomized run; the model compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 149) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
